// File: rtl/uart_program_loader.sv
// Program loader: pulls a program image from the UART RX FIFO into instruction memory while holding the pipeline.
// Optional trailing checksum byte enabled with `define LOADER_CHECKSUM_EN.
module uart_program_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  START_CMD = 8'h4C,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        uartFifoDataIn,
    input  logic              uartDataAvailable,
    output logic              readFifoFlag,
    output logic [7:0]        dataToUartOutFifo,
    output logic              writeFifoFlag,
    output logic              imemWe,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [31:0]       imemData,
    output logic              pipeHold,
    output logic              loadDone,
    output logic              loadError,
    output logic [ADDR_W:0]   wordCount
);

    // Internal counter is at least 9 bits so any N byte is reachable even when ADDR_W < 8.
    localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_BYTE, S_WRITE, S_CSUM, S_REPLY, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               rd_q, rd_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   target_q, target_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
    logic               err_q, err_d;
`endif

    logic receiving;
    logic take;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            word_q     <= '0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            target_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            err_q      <= err_d;
`endif
        end
    end

    // A byte is consumed on the edge that raises readFifoFlag; the flag-high cycle is the mandatory gap.
    always_comb begin
        receiving  = (state_q == S_IDLE) || (state_q == S_COUNT) || (state_q == S_BYTE) ||
                     (state_q == S_CSUM) || (state_q == S_DONE);
        take       = receiving && uartDataAvailable && !rd_q;
        state_d    = state_q;
        rd_d       = take;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (take && uartFifoDataIn == START_CMD) begin
                    state_d = S_COUNT;
                    cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_COUNT: begin
                if (take) begin
                    target_d   = (uartFifoDataIn == 8'h00) ? (CNT_W'(1) << ADDR_W)
                                                           : CNT_W'(uartFifoDataIn);
                    addr_d     = '0;
                    byte_idx_d = '0;
                    state_d    = S_BYTE;
                end
            end
            S_BYTE: begin
                if (take) begin
                    word_d     = {word_q[23:0], uartFifoDataIn};
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ uartFifoDataIn;
`endif
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q + CNT_W'(1) == target_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_REPLY;
`endif
                end else begin
                    state_d = S_BYTE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (take) begin
                    err_d   = (uartFifoDataIn != csum_q);
                    state_d = S_REPLY;
                end
            end
`endif
            S_REPLY: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        readFifoFlag      = rd_q;
        imemWe            = (state_q == S_WRITE);
        imemAddr          = addr_q;
        imemData          = word_q;
        wordCount         = cnt_q[ADDR_W:0];
        pipeHold          = (state_q == S_COUNT) || (state_q == S_BYTE) || (state_q == S_WRITE) ||
                            (state_q == S_CSUM)  || (state_q == S_REPLY);
        loadDone          = (state_q == S_DONE);
        writeFifoFlag     = (state_q == S_REPLY);
        dataToUartOutFifo = '0;
`ifdef LOADER_CHECKSUM_EN
        loadError         = err_q;
        if (state_q == S_REPLY) begin
            dataToUartOutFifo = err_q ? NAK_BYTE : ACK_BYTE;
        end
`else
        loadError         = 1'b0;
        if (state_q == S_REPLY) begin
            dataToUartOutFifo = ACK_BYTE;
        end
`endif
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: RX FIFO model, write/TX capture, per-scenario checks.
// Checksum scenarios follow `define LOADER_CHECKSUM_EN.
module tb_uart_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  uartFifoDataIn;
    logic        uartDataAvailable;
    logic        readFifoFlag;
    logic [7:0]  dataToUartOutFifo;
    logic        writeFifoFlag;
    logic        imemWe;
    logic [7:0]  imemAddr;
    logic [31:0] imemData;
    logic        pipeHold;
    logic        loadDone;
    logic        loadError;
    logic [8:0]  wordCount;

    uart_program_loader #(
        .ADDR_W(8), .START_CMD(8'h4C), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
    ) dut (
        .clock(clock), .reset(reset),
        .uartFifoDataIn(uartFifoDataIn), .uartDataAvailable(uartDataAvailable),
        .readFifoFlag(readFifoFlag), .dataToUartOutFifo(dataToUartOutFifo),
        .writeFifoFlag(writeFifoFlag), .imemWe(imemWe), .imemAddr(imemAddr),
        .imemData(imemData), .pipeHold(pipeHold), .loadDone(loadDone),
        .loadError(loadError), .wordCount(wordCount)
    );

    always #5 clock = ~clock;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] mem_model [256];
    int total = 0;
    int bad = 0;
    int rd_viol = 0, both_viol = 0, hold_viol = 0, pop_cnt = 0;
    logic rd_prev = 1'b0;

    // FIFO model and capture, all on the falling edge so the DUT sees stable inputs at posedge.
    task automatic monitor();
        forever begin
            @(negedge clock);
            if (readFifoFlag && !uartDataAvailable) rd_viol++;
            if (readFifoFlag && rd_prev) rd_viol++;
            rd_prev = readFifoFlag;
            if (imemWe && writeFifoFlag) both_viol++;
            if (imemWe) begin
                wr_addr_log.push_back(imemAddr);
                wr_data_log.push_back(imemData);
                mem_model[imemAddr] = imemData;
                if (!pipeHold) hold_viol++;
            end
            if (writeFifoFlag) begin
                tx_log.push_back(dataToUartOutFifo);
                if (!pipeHold) hold_viol++;
            end
            if (readFifoFlag && rx_q.size() > 0) begin
                void'(rx_q.pop_front());
                pop_cnt++;
            end
            uartDataAvailable = (rx_q.size() != 0);
            uartFifoDataIn    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
    endtask

    function automatic logic [7:0] xor_word(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    task automatic push_word(input logic [31:0] w);
        rx_q.push_back(w[31:24]);
        rx_q.push_back(w[23:16]);
        rx_q.push_back(w[15:8]);
        rx_q.push_back(w[7:0]);
    endtask

    task automatic clear_logs();
        tx_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_viol = 0; both_viol = 0; hold_viol = 0; pop_cnt = 0;
    endtask

    task automatic wait_tx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (tx_log.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({readFifoFlag, writeFifoFlag, imemWe, pipeHold, loadDone, loadError} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=000000",
                {readFifoFlag, writeFifoFlag, imemWe, pipeHold, loadDone, loadError});
        end
        total++;
        if ({imemAddr, imemData, wordCount, dataToUartOutFifo} !== '0) begin
            bad++; $display("FAIL reset_data addr=%h data=%h wc=%0d tx=%h want all 0",
                imemAddr, imemData, wordCount, dataToUartOutFifo);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic_load();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h4C); rx_q.push_back(8'h02);
        push_word(32'h0000_0011); push_word(32'h1234_5678);
`ifdef LOADER_CHECKSUM_EN
        rx_q.push_back(xor_word(32'h0000_0011) ^ xor_word(32'h1234_5678));
`endif
        wait_tx(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout got=no reply want=reply"); end
        total++;
        if (wr_data_log.size() != 2) begin
            bad++; $display("FAIL basic_nwrites got=%0d want=2", wr_data_log.size());
        end else begin
            total++;
            if (wr_addr_log[0] !== 8'd0 || wr_data_log[0] !== 32'h0000_0011) begin
                bad++; $display("FAIL basic_w0 got=[%h]=%h want=[00]=00000011", wr_addr_log[0], wr_data_log[0]);
            end
            total++;
            if (wr_addr_log[1] !== 8'd1 || wr_data_log[1] !== 32'h1234_5678) begin
                bad++; $display("FAIL basic_w1 got=[%h]=%h want=[01]=12345678", wr_addr_log[1], wr_data_log[1]);
            end
        end
        total++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
            bad++; $display("FAIL basic_tx got n=%0d b0=%h want n=1 06", tx_log.size(), tx_log[0]);
        end
        total++;
        if (wordCount !== 9'd2 || loadDone !== 1'b1 || pipeHold !== 1'b0 || loadError !== 1'b0) begin
            bad++; $display("FAIL basic_status got wc=%0d done=%b hold=%b err=%b want 2 1 0 0",
                wordCount, loadDone, pipeHold, loadError);
        end
        total++;
        if (hold_viol != 0) begin bad++; $display("FAIL basic_hold got=%0d want=0", hold_viol); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_error();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h4C); rx_q.push_back(8'h02);
        push_word(32'h0000_0011); push_word(32'h1234_5678);
        rx_q.push_back(8'h00);
        wait_tx(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nak_timeout got=no reply want=reply"); end
        total++;
        if (wr_data_log.size() != 2) begin
            bad++; $display("FAIL nak_nwrites got=%0d want=2", wr_data_log.size());
        end
        total++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h15) begin
            bad++; $display("FAIL nak_tx got n=%0d b0=%h want n=1 15", tx_log.size(), tx_log[0]);
        end
        total++;
        if (loadError !== 1'b1 || loadDone !== 1'b1) begin
            bad++; $display("FAIL nak_status got err=%b done=%b want 1 1", loadError, loadDone);
        end
    endtask
`endif

    task automatic test_discard();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h00); rx_q.push_back(8'hFF);
        rx_q.push_back(8'h4C); rx_q.push_back(8'h01);
        push_word(32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
        rx_q.push_back(8'h22);
`endif
        wait_tx(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL discard_timeout got=no reply want=reply"); end
        total++;
        if (wr_data_log.size() != 1 || wr_addr_log[0] !== 8'd0 || wr_data_log[0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL discard_write got n=%0d [%h]=%h want n=1 [00]=deadbeef",
                wr_data_log.size(), wr_addr_log[0], wr_data_log[0]);
        end
        total++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
            bad++; $display("FAIL discard_tx got n=%0d b0=%h want n=1 06", tx_log.size(), tx_log[0]);
        end
        total++;
        if (wordCount !== 9'd1 || loadError !== 1'b0) begin
            bad++; $display("FAIL discard_status got wc=%0d err=%b want 1 0", wordCount, loadError);
        end
    endtask

    task automatic test_full_256();
        bit ok;
        logic [7:0]  cs;
        logic [7:0]  iv;
        logic [31:0] w;
        clear_logs();
        cs = 8'h00;
        rx_q.push_back(8'h4C); rx_q.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            w  = {iv, ~iv, 8'(i * 3), 8'h5A};
            cs = cs ^ xor_word(w);
            push_word(w);
        end
`ifdef LOADER_CHECKSUM_EN
        rx_q.push_back(cs);
`endif
        wait_tx(4000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full_timeout got=no reply want=reply"); end
        total++;
        if (wr_data_log.size() != 256) begin
            bad++; $display("FAIL full_nwrites got=%0d want=256", wr_data_log.size());
        end else begin
            for (int i = 0; i < 256; i++) begin
                iv = 8'(i);
                w  = {iv, ~iv, 8'(i * 3), 8'h5A};
                total++;
                if (wr_addr_log[i] !== iv || wr_data_log[i] !== w) begin
                    bad++; $display("FAIL full_word%0d got=[%h]=%h want=[%h]=%h",
                        i, wr_addr_log[i], wr_data_log[i], iv, w);
                end
            end
        end
        total++;
        if (wordCount !== 9'd256) begin bad++; $display("FAIL full_wordcount got=%0d want=256", wordCount); end
        total++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
            bad++; $display("FAIL full_tx got n=%0d b0=%h want n=1 06", tx_log.size(), tx_log[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        clear_logs();
        rx_q.push_back(8'h4C); rx_q.push_back(8'h02);
        push_word(32'h0000_0011);
        rx_q.push_back(8'h12); rx_q.push_back(8'h34);
        repeat (40) @(negedge clock);
        total++;
        if (pipeHold !== 1'b1 || wr_data_log.size() != 1) begin
            bad++; $display("FAIL midrst_pre got hold=%b nwr=%0d want 1 1", pipeHold, wr_data_log.size());
        end
        reset = 1'b1;
        #1;
        total++;
        if ({pipeHold, readFifoFlag, imemWe, writeFifoFlag, loadDone} !== 5'b0 ||
            imemAddr !== 8'd0 || wordCount !== 9'd0 || imemData !== 32'd0) begin
            bad++; $display("FAIL midrst_outputs got hold=%b addr=%h wc=%0d data=%h want all 0",
                pipeHold, imemAddr, wordCount, imemData);
        end
        @(negedge clock);
        reset = 1'b0;
        total++;
        if (mem_model[0] !== 32'h0000_0011) begin
            bad++; $display("FAIL midrst_word0 got=%h want=00000011", mem_model[0]);
        end
        clear_logs();
        rx_q.push_back(8'h4C); rx_q.push_back(8'h01);
        push_word(32'hCAFE_BABE);
`ifdef LOADER_CHECKSUM_EN
        rx_q.push_back(xor_word(32'hCAFE_BABE));
`endif
        wait_tx(200, ok);
        total++;
        if (!ok || tx_log.size() != 1 || tx_log[0] !== 8'h06) begin
            bad++; $display("FAIL midrst_reload_tx got n=%0d b0=%h want n=1 06", tx_log.size(), tx_log[0]);
        end
        total++;
        if (wr_data_log.size() != 1 || wr_data_log[0] !== 32'hCAFE_BABE || wordCount !== 9'd1) begin
            bad++; $display("FAIL midrst_reload_write got n=%0d d=%h wc=%0d want 1 cafebabe 1",
                wr_data_log.size(), wr_data_log[0], wordCount);
        end
    endtask

    task automatic test_fifo_protocol();
        bit ok;
        int expect_pops;
        clear_logs();
        rx_q.push_back(8'h4C); rx_q.push_back(8'h02);
        push_word(32'hA1B2_C3D4); push_word(32'h0F1E_2D3C);
        expect_pops = 10;
`ifdef LOADER_CHECKSUM_EN
        rx_q.push_back(xor_word(32'hA1B2_C3D4) ^ xor_word(32'h0F1E_2D3C));
        expect_pops = 11;
`endif
        wait_tx(200, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL proto_timeout got=no reply want=reply"); end
        total++;
        if (rd_viol != 0) begin bad++; $display("FAIL proto_pop_rule got=%0d violations want=0", rd_viol); end
        total++;
        if (both_viol != 0) begin bad++; $display("FAIL proto_we_tx_overlap got=%0d want=0", both_viol); end
        total++;
        if (pop_cnt != expect_pops) begin
            bad++; $display("FAIL proto_pop_count got=%0d want=%0d", pop_cnt, expect_pops);
        end
        total++;
        if (hold_viol != 0) begin bad++; $display("FAIL proto_hold got=%0d want=0", hold_viol); end
    endtask

    initial begin
        reset             = 1'b1;
        uartDataAvailable = 1'b0;
        uartFifoDataIn    = 8'h00;
        fork
            monitor();
        join_none
        test_reset();
        test_basic_load();
`ifdef LOADER_CHECKSUM_EN
        test_checksum_error();
`endif
        test_discard();
        test_full_256();
        test_reset_mid_load();
        test_fifo_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
